// File: rtl/spi_xfer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : spi_xfer_seq                                                    |
// | Purpose : Burst sequencer in front of the SPI word engine. Host TX words |
// |           are queued in a TX FIFO and handed to the engine one at a time |
// |           through a start/tx_data handshake; each received word goes     |
// |           into an RX FIFO. A go command runs burst_len words, then a     |
// |           one-cycle done pulse is raised.                                |
// | Ports   : clk/rst_n         clock, async active-low reset                 |
// |           tx_*              host TX FIFO write side and status           |
// |           rx_*              host RX FIFO read side (show-ahead), status  |
// |           burst_len/go/abort/flush  burst control                        |
// |           busy/done/rx_ovf  burst status                                 |
// |           fsm_*             handshake with the SPI word engine           |
// | Option  : SPI_XFER_RX_BACKPRESSURE_EN - when defined, a word is only     |
// |           issued while the RX FIFO has room, so nothing is ever dropped  |
// |           and rx_ovf stays 0. Otherwise a word completing into a full    |
// |           RX FIFO is dropped and rx_ovf is set (sticky until flush).     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module spi_xfer_seq #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_W-1:0]               tx_wdata,
  input  logic                            tx_push,
  output logic                            tx_full,
  output logic [$clog2(FIFO_DEPTH):0]     tx_level,
  output logic [WORD_W-1:0]               rx_rdata,
  input  logic                            rx_pop,
  output logic                            rx_empty,
  input  logic [LEN_W-1:0]                burst_len,
  input  logic                            go,
  input  logic                            abort,
  input  logic                            flush,
  output logic                            busy,
  output logic                            done,
  output logic                            rx_ovf,
  output logic                            fsm_start,
  output logic [WORD_W-1:0]               fsm_tx_data,
  output logic                            fsm_tx_data_valid,
  input  logic [WORD_W-1:0]               fsm_rx_data,
  input  logic                            fsm_rx_data_valid,
  input  logic                            fsm_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;

  logic [WORD_W-1:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_tx_wr, r_tx_rd;
  logic [CW-1:0]      r_tx_cnt;
  logic [WORD_W-1:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_rx_wr, r_rx_rd;
  logic [CW-1:0]      r_rx_cnt;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_flush, w_load_ok, w_word_fire, w_word_done;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == C_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == C_FULL);

  // Flush only acts between bursts so an in-flight burst never loses data.
  assign w_flush = flush && (r_state == S_IDLE);

`ifdef SPI_XFER_RX_BACKPRESSURE_EN
  // Hold off the next word until the host has made room for its reply.
  assign w_load_ok = !w_tx_empty && !w_rx_full;
`else
  assign w_load_ok = !w_tx_empty;
`endif

  // A same-cycle pop frees a slot, so a push into a full FIFO is taken then.
  assign w_tx_pop  = w_word_fire;
  assign w_tx_push = tx_push && (!w_tx_full || w_tx_pop) && !w_flush;
  assign w_rx_pop  = rx_pop && !w_rx_empty && !w_flush;
  assign w_rx_push = w_word_done && fsm_rx_data_valid && (!w_rx_full || w_rx_pop);

  // ---------------- state machine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_word_fire     = 1'b0;
    w_word_done     = 1'b0;
    if (abort) begin
      // Abort beats everything, including a same-cycle go or fsm_done.
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go && (burst_len != '0)) begin
            w_state_nxt     = S_LOAD;
            w_remaining_nxt = burst_len;
          end
        end
        S_LOAD: begin
          if (w_load_ok) begin
            w_word_fire = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fsm_done) begin
            w_word_done     = 1'b1;
            w_remaining_nxt = r_remaining - LEN_W'(1);
            w_state_nxt     = (r_remaining == LEN_W'(1)) ? S_DONE : S_LOAD;
          end
        end
        default: w_state_nxt = S_IDLE;   // S_DONE
      endcase
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE) && !abort;
  assign fsm_start         = w_word_fire;
  assign fsm_tx_data_valid = w_word_fire;
  assign fsm_tx_data       = w_word_fire ? r_tx_mem[r_tx_rd] : '0;

  // ---------------- TX FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else if (w_flush) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + CW'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
    end
  end

  assign tx_full  = w_tx_full;
  assign tx_level = r_tx_cnt;

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= fsm_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else if (w_flush) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CW'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
    end
  end

  assign rx_empty = w_rx_empty;
  // Storage is not reset; hide stale contents while empty.
  assign rx_rdata = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];

`ifdef SPI_XFER_RX_BACKPRESSURE_EN
  assign rx_ovf = 1'b0;
`else
  logic r_rx_ovf;
  logic w_rx_drop;

  assign w_rx_drop = w_word_done && fsm_rx_data_valid && !w_rx_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rx_ovf <= 1'b0;
    else if (w_flush)   r_rx_ovf <= 1'b0;
    else if (w_rx_drop) r_rx_ovf <= 1'b1;
  end

  assign rx_ovf = r_rx_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_spi_xfer_seq                                                 |
// | Purpose : Self-checking bench for spi_xfer_seq. A behavioural engine     |
// |           answers each fsm_start after a programmable latency; a queue   |
// |           model of the TX FIFO predicts the words sent in random bursts. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spi_xfer_seq;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WORD_W-1:0] tx_wdata;
  logic              tx_push;
  logic              tx_full;
  logic [3:0]        tx_level;
  logic [WORD_W-1:0] rx_rdata;
  logic              rx_pop;
  logic              rx_empty;
  logic [LEN_W-1:0]  burst_len;
  logic              go, abort, flush;
  logic              busy, done, rx_ovf;
  logic              fsm_start;
  logic [WORD_W-1:0] fsm_tx_data;
  logic              fsm_tx_data_valid;
  logic [WORD_W-1:0] fsm_rx_data;
  logic              fsm_rx_data_valid;
  logic              fsm_done;

  spi_xfer_seq #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_wdata(tx_wdata), .tx_push(tx_push), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rdata(rx_rdata), .rx_pop(rx_pop), .rx_empty(rx_empty),
    .burst_len(burst_len), .go(go), .abort(abort), .flush(flush),
    .busy(busy), .done(done), .rx_ovf(rx_ovf),
    .fsm_start(fsm_start), .fsm_tx_data(fsm_tx_data), .fsm_tx_data_valid(fsm_tx_data_valid),
    .fsm_rx_data(fsm_rx_data), .fsm_rx_data_valid(fsm_rx_data_valid), .fsm_done(fsm_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // engine model state
  logic              eng_en = 1'b0;
  int                eng_lat = 1;
  logic              eng_valid_rand = 1'b0;
  int                pend = 0;
  logic [WORD_W-1:0] sent_q[$];
  logic [WORD_W-1:0] ret_q[$];
  logic [WORD_W-1:0] rx_resp_q[$];
  logic [WORD_W-1:0] tx_model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine: answers each fsm_start with fsm_done eng_lat cycles later.
  initial begin
    logic [WORD_W-1:0] d;
    logic              v;
    fsm_done = 1'b0; fsm_rx_data = '0; fsm_rx_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_en) begin
        fsm_done = 1'b0; fsm_rx_data_valid = 1'b0;
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            d = (rx_resp_q.size() != 0) ? rx_resp_q.pop_front() : WORD_W'($urandom);
            v = eng_valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            fsm_done = 1'b1; fsm_rx_data = d; fsm_rx_data_valid = v;
            if (v) ret_q.push_back(d);
          end
        end
        if (fsm_start) begin
          sent_q.push_back(fsm_tx_data);
          pend = eng_lat;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [WORD_W-1:0] d);
    tx_push = 1'b1; tx_wdata = d;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic start_burst(input int len);
    burst_len = LEN_W'(len); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic drain_rx(input int n);
    for (int i = 0; i < n; i++) begin
      chk("rx_not_empty", 32'(rx_empty), 0);
      chk("rx_data", 32'(rx_rdata), 32'(ret_q.pop_front()));
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
    end
  endtask

  typedef struct {
    logic [WORD_W-1:0] data;
    int                exp_level;
    logic              exp_full;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   d0, k, len, n;
    logic [WORD_W-1:0] rd;

    rst_n = 1'b0; tx_wdata = '0; tx_push = 1'b0; rx_pop = 1'b0; burst_len = '0;
    go = 1'b0; abort = 1'b0; flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vecs[i].data      = WORD_W'(8'hC0 + i);
      vecs[i].exp_level = (i < 8) ? i + 1 : 8;
      vecs[i].exp_full  = (i >= 7);
    end

    // ---- reset values ----
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_tx_level", 32'(tx_level), 0);
    chk("rst_rx_ovf", 32'(rx_ovf), 0);
    chk("rst_fsm_start", 32'(fsm_start), 0);
    chk("rst_fsm_valid", 32'(fsm_tx_data_valid), 0);
    chk("rst_rx_rdata", 32'(rx_rdata), 0);
    rst_n = 1'b1;
    tick(1);
    eng_en = 1'b1; eng_lat = 1;

    // ---- basic burst ----
    push_tx(8'hA5); push_tx(8'h3C);
    rx_resp_q.push_back(8'h11); rx_resp_q.push_back(8'h22);
    d0 = done_cnt;
    start_burst(2);
    wait_idle(100);
    chk("basic_nsent", sent_q.size(), 2);
    chk("basic_tx0", 32'(sent_q[0]), 32'h A5);
    chk("basic_tx1", 32'(sent_q[1]), 32'h3C);
    chk("basic_done", done_cnt - d0, 1);
    drain_rx(2);
    chk("basic_rx_empty", 32'(rx_empty), 1);

    // ---- underflow stall ----
    sent_q.delete(); ret_q.delete();
    push_tx(8'h10);
    d0 = done_cnt;
    start_burst(3);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (fsm_start && i > 2) n++;
      @(negedge clk);
    end
    chk("uf_busy", 32'(busy), 1);
    chk("uf_nsent", sent_q.size(), 1);
    chk("uf_start_low", n, 0);
    push_tx(8'h77);
    tick(4);
    chk("uf_nsent2", sent_q.size(), 2);
    chk("uf_tx77", 32'(sent_q[1]), 32'h77);
    push_tx(8'h99);
    wait_idle(100);
    chk("uf_done", done_cnt - d0, 1);
    drain_rx(3);

    // ---- TX FIFO boundary (table) ----
    for (int i = 0; i < 9; i++) begin
      push_tx(vecs[i].data);
      chk("tbl_level", 32'(tx_level), 32'(vecs[i].exp_level));
      chk("tbl_full", 32'(tx_full), 32'(vecs[i].exp_full));
    end
    sent_q.delete(); ret_q.delete();
    burst_len = 8'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("full_pp_start", 32'(fsm_start), 1);
    tx_push = 1'b1; tx_wdata = 8'hEE;
    @(negedge clk);
    tx_push = 1'b0;
    chk("full_pp_level", 32'(tx_level), 8);
    chk("full_pp_full", 32'(tx_full), 1);
    wait_idle(100);
    drain_rx(1);
    sent_q.delete();
    start_burst(8);
    wait_idle(200);
    for (int i = 0; i < 7; i++) chk("full_order", 32'(sent_q[i]), 32'(vecs[i + 1].data));
    chk("full_order_last", 32'(sent_q[7]), 32'hEE);
    drain_rx(8);

    // ---- abort mid-word ----
    eng_en = 1'b0;
    ret_q.delete();
    push_tx(8'h42);
    d0 = done_cnt;
    start_burst(1);
    chk("ab_start", 32'(fsm_start), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    fsm_done = 1'b1; fsm_rx_data = 8'h5A; fsm_rx_data_valid = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0; fsm_rx_data_valid = 1'b0;
    tick(2);
    chk("ab_rx_empty", 32'(rx_empty), 1);
    chk("ab_no_done", done_cnt - d0, 0);
    // abort and go together
    push_tx(8'h43);
    burst_len = 8'd3; go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    chk("ab_go_busy", 32'(busy), 0);
    chk("ab_go_level", 32'(tx_level), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    eng_en = 1'b1;

    // ---- RX full ----
    sent_q.delete(); ret_q.delete();
    for (int i = 0; i < 8; i++) push_tx(WORD_W'(8'h50 + i));
    d0 = done_cnt;
    start_burst(9);
    push_tx(8'h58);
`ifdef SPI_XFER_RX_BACKPRESSURE_EN
    tick(30);
    chk("bp_stall_busy", 32'(busy), 1);
    chk("bp_stall_nsent", sent_q.size(), 8);
    drain_rx(1);
    wait_idle(100);
    chk("bp_nsent", sent_q.size(), 9);
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_ovf", 32'(rx_ovf), 0);
    drain_rx(8);
`else
    wait_idle(200);
    chk("ovf_nsent", sent_q.size(), 9);
    chk("ovf_done", done_cnt - d0, 1);
    chk("ovf_flag", 32'(rx_ovf), 1);
    drain_rx(8);
    chk("ovf_rx_empty", 32'(rx_empty), 1);
    chk("ovf_sticky", 32'(rx_ovf), 1);
`endif
    ret_q.delete();

    // ---- edge commands ----
    d0 = done_cnt;
    start_burst(0);
    chk("len0_busy", 32'(busy), 0);
    tick(3);
    chk("len0_busy2", 32'(busy), 0);
    chk("len0_done", done_cnt - d0, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ovf", 32'(rx_ovf), 0);
    push_tx(8'h31);
    start_burst(2);
    tick(10);
    chk("fb_busy", 32'(busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fb_rx_kept", 32'(rx_empty), 0);
    chk("fb_rx_data", 32'(rx_rdata), 32'(ret_q[0]));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("fb_abort_idle", 32'(busy), 0);
    chk("fb_no_done", done_cnt - d0, 0);
    push_tx(8'h32);
    flush = 1'b1; tx_push = 1'b1; tx_wdata = 8'h33; rx_pop = 1'b1;
    @(negedge clk);
    flush = 1'b0; tx_push = 1'b0; rx_pop = 1'b0;
    chk("fi_tx_level", 32'(tx_level), 0);
    chk("fi_rx_empty", 32'(rx_empty), 1);
    ret_q.delete();

    // ---- randomized bursts against queue model ----
    eng_valid_rand = 1'b1;
    for (int it = 0; it < 20; it++) begin
      k = $urandom_range(0, 10);
      for (int j = 0; j < k; j++) begin
        rd = WORD_W'($urandom);
        push_tx(rd);
        if (tx_model.size() < DEPTH) tx_model.push_back(rd);
      end
      chk("rand_level", 32'(tx_level), tx_model.size());
      if (tx_model.size() != 0) begin
        len = $urandom_range(1, tx_model.size());
        eng_lat = $urandom_range(1, 4);
        sent_q.delete(); ret_q.delete();
        d0 = done_cnt;
        start_burst(len);
        wait_idle(400);
        chk("rand_nsent", sent_q.size(), len);
        for (int j = 0; j < len; j++) chk("rand_tx", 32'(sent_q[j]), 32'(tx_model.pop_front()));
        chk("rand_done", done_cnt - d0, 1);
        drain_rx(ret_q.size());
        chk("rand_rx_empty", 32'(rx_empty), 1);
      end
    end
    eng_valid_rand = 1'b0;

    // ---- reset mid-burst ----
    eng_en = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_tx(8'h6D);
    start_burst(2);
    chk("mr_start_before", 32'(fsm_start), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_start", 32'(fsm_start), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_level", 32'(tx_level), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
